// File: rtl/fifo_drain.sv
// fifo_drain
//   Read-side controller for a 16x8 register FIFO. It tracks FIFO occupancy from
//   the write strobe, issues the FIFO read enable (1-cycle read latency), captures
//   the returned words into a 2-entry output buffer and presents them on a
//   valid/ready stream.
//
// Ports
//   clk          rising-edge clock shared with the FIFO
//   reset        synchronous active-low reset (0 = reset)
//   wr_strobe    copy of the FIFO write enable, used for occupancy tracking only
//   fifo_en_read FIFO read enable (registered)
//   fifo_data    FIFO read data, valid the cycle after fifo_en_read
//   out_data     head of the output buffer
//   out_valid    output buffer non-empty
//   out_ready    consumer accepts out_data when out_valid && out_ready
//   count        words held in the FIFO (excludes in-flight and buffered words)
//   empty        count == 0
//   full         count == DEPTH
//   overflow     sticky; write arrived while full with no read; cleared by reset
//
// Buffer FSM
//   state | meaning
//   B0    | buffer empty, out_valid=0, out_data holds its last value
//   B1    | one word buffered, presented on out_data
//   B2    | two words buffered, head on out_data, second word in tail

module fifo_drain #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_strobe,
    output logic              fifo_en_read,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } buf_state_t;

    buf_state_t        buf_state;
    buf_state_t        buf_state_next;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [DATA_W-1:0] head_next;
    logic [DATA_W-1:0] tail_next;
    logic              inflight;
    logic [CNT_W-1:0]  count_next;
    logic              en_next;
    logic              overflow_next;
    logic              wr_acc;
    logic              pop;
    logic              capture;
    logic [1:0]        buf_cnt_next;

    assign out_valid = (buf_state != B0);
    assign out_data  = head_q;
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

    always_comb begin
        buf_state_next = buf_state;
        head_next      = head_q;
        tail_next      = tail_q;
        pop            = out_valid && out_ready;
        capture        = inflight;

        case (buf_state)
            B0: begin
                if (capture) begin
                    head_next      = fifo_data;
                    buf_state_next = B1;
                end
            end
            B1: begin
                if (capture && pop) begin
                    head_next = fifo_data;
                end else if (capture) begin
                    tail_next      = fifo_data;
                    buf_state_next = B2;
                end else if (pop) begin
                    buf_state_next = B0;
                end
            end
            B2: begin
                // The credit rule keeps capture from ever landing in B2.
                if (pop) begin
                    head_next      = tail_q;
                    buf_state_next = B1;
                end
            end
            default: begin
                buf_state_next = B0;
            end
        endcase

        buf_cnt_next = buf_state_next;
    end

    always_comb begin
        wr_acc        = wr_strobe && ((count < CNT_W'(DEPTH)) || fifo_en_read);
        count_next    = count + CNT_W'(wr_acc) - CNT_W'(fifo_en_read);
        overflow_next = overflow ||
                        (wr_strobe && (count == CNT_W'(DEPTH)) && !fifo_en_read);
        // Occupancy is taken after this edge's write/read so a word written now is
        // read on the following edge and the last word is never read twice.
        // The credit counts buffered words plus the read already on its way; the
        // read being issued here is the one that may fill the last slot.
        en_next = (count_next != '0) &&
                  (({1'b0, buf_cnt_next} + {2'b00, fifo_en_read}) < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_state    <= B0;
            head_q       <= '0;
            tail_q       <= '0;
            inflight     <= 1'b0;
            fifo_en_read <= 1'b0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            buf_state    <= buf_state_next;
            head_q       <= head_next;
            tail_q       <= tail_next;
            inflight     <= fifo_en_read;
            fifo_en_read <= en_next;
            count        <= count_next;
            overflow     <= overflow_next;
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain
//   Bench for fifo_drain: a behavioural 16-entry FIFO drives fifo_data, a
//   negedge monitor keeps an occupancy/overflow model plus an ordered queue of
//   written words and checks every word leaving the stream against it.

module tb_fifo_drain;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_strobe;
    logic [DATA_W-1:0] wr_data;
    logic              fifo_en_read;
    logic [DATA_W-1:0] fifo_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    fifo_drain #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_strobe    (wr_strobe),
        .fifo_en_read (fifo_en_read),
        .fifo_data    (fifo_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural register FIFO, read data valid one cycle after the enable.
    logic [DATA_W-1:0] fmem [DEPTH];
    logic [3:0]        wptr;
    logic [3:0]        rptr;

    always @(posedge clk) begin
        if (!reset) begin
            wptr      <= '0;
            rptr      <= '0;
            fifo_data <= '0;
        end else begin
            if (fifo_en_read) begin
                fifo_data <= fmem[rptr];
                rptr      <= rptr + 4'd1;
            end else begin
                fifo_data <= '0;
            end
            if (wr_strobe) begin
                fmem[wptr] <= wr_data;
                wptr       <= wptr + 4'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: occupancy, overflow flag and the ordered list of words
    // the consumer must see. Outputs are compared against the state reached at
    // the previous edge, then the model is advanced with the inputs that the
    // next edge will sample.
    logic [DATA_W-1:0] exp_q [$];
    int                occ = 0;
    bit                ovf = 1'b0;
    bit                armed = 1'b0;
    bit                hold = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] want;

    always @(negedge clk) begin
        if (armed) begin
            chk("count", count, occ);
            chk("empty", empty, occ == 0);
            chk("full", full, occ == DEPTH);
            chk("overflow", overflow, ovf);
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
            end
        end
        if (!reset) begin
            occ   = 0;
            ovf   = 1'b0;
            hold  = 1'b0;
            armed = 1'b1;
            exp_q.delete();
        end else if (armed) begin
            if (fifo_en_read) chk("read_nonempty", occ > 0, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    if (!ovf) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_word actual=%0h required=none", out_data);
                    end
                end else begin
                    want = exp_q.pop_front();
                    if (!ovf) chk("stream_data", out_data, want);
                end
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            if (wr_strobe) begin
                if (occ < DEPTH || fifo_en_read) begin
                    occ++;
                    exp_q.push_back(wr_data);
                end else begin
                    ovf = 1'b1;
                end
            end
            if (fifo_en_read && occ > 0) occ--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n         = 0;
        out_ready = 1'b1;
        wr_strobe = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        chk({name, "_idle"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;

        // 1: reset held for 2 cycles with random inputs
        reset     = 1'b0;
        wr_data   = '0;
        wr_strobe = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_strobe = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            wr_data   = 8'($urandom);
            tick();
        end
        chk("rst_en", fifo_en_read, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        reset     = 1'b1;
        wr_strobe = 1'b0;
        out_ready = 1'b0;

        // 2: single word latency
        out_ready = 1'b1;
        wr_strobe = 1'b1;
        wr_data   = 8'hA5;
        tick();
        wr_strobe = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            chk("single_en", fifo_en_read, k == 0);
            chk("single_valid", out_valid, k == 2);
            if (k == 2) chk("single_data", out_data, 8'hA5);
        end
        chk("single_count", count, 0);

        // 3: burst of 16 with the consumer stalled, then released
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_strobe = 1'b1;
            wr_data   = 8'(i);
            tick();
        end
        wr_strobe = 1'b0;
        chk("burst_count", count, 14);
        chk("burst_full", full, 0);
        chk("burst_valid", out_valid, 1);
        chk("burst_head", out_data, 8'h00);
        drain("burst_drain");

        // 4: overflow after 19 writes with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            wr_strobe = 1'b1;
            wr_data   = 8'($urandom);
            tick();
            if (i == 17) begin
                chk("ovf18_count", count, 16);
                chk("ovf18_full", full, 1);
                chk("ovf18_flag", overflow, 0);
            end
        end
        wr_strobe = 1'b0;
        chk("ovf19_flag", overflow, 1);
        chk("ovf19_count", count, 16);
        tick();
        chk("ovf_sticky", overflow, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("ovf_clr", overflow, 0);
        chk("ovf_clr_count", count, 0);

        // 5: 40 words with out_ready toggling every cycle
        sent = 0;
        cyc  = 0;
        while (sent < 40 && cyc < 400) begin
            out_ready = (cyc % 2 == 0);
            wr_strobe = (occ < 12) && 1'($urandom_range(0, 1));
            wr_data   = 8'($urandom);
            if (wr_strobe) sent++;
            tick();
            cyc++;
        end
        chk("bp_sent", sent, 40);
        drain("bp_drain");

        // random traffic, writes kept below overflow
        for (int i = 0; i < 600; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            wr_strobe = (occ < 15) && 1'($urandom_range(0, 1));
            wr_data   = 8'($urandom);
            tick();
        end
        drain("rand_drain");

        // 6: mid-stream reset with buffer full and count=5
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_strobe = 1'b1;
            wr_data   = 8'(8'h50 + i);
            tick();
        end
        wr_strobe = 1'b0;
        chk("mid_count", count, 5);
        chk("mid_valid", out_valid, 1);
        chk("mid_head", out_data, 8'h50);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_en", fifo_en_read, 0);
        out_ready = 1'b1;
        wr_strobe = 1'b1;
        wr_data   = 8'h3C;
        tick();
        wr_strobe = 1'b0;
        tick();
        tick();
        chk("post_valid", out_valid, 1);
        chk("post_data", out_data, 8'h3C);
        drain("post_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
